// File: rtl/axi_slave_responder.sv
// AXI4 slave backed by a small word memory, with independent write (W_IDLE/W_DATA/W_RESP)
// and read (R_IDLE/R_DATA) FSMs. Optional macro AXI_SLV_RANGE_CHECK_EN enables out-of-window SLVERR.
module axi_slave_responder #(
    parameter int unsigned           ID_WIDTH   = 4,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_WORDS  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ID_WIDTH-1:0]   S_AWID,
    input  logic [ADDR_WIDTH-1:0] S_AWADDR,
    input  logic [3:0]            S_AWLEN,
    input  logic [1:0]            S_AWBURST,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [31:0]           S_WDATA,
    input  logic [3:0]            S_WSTRB,
    input  logic                  S_WLAST,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    output logic [ID_WIDTH-1:0]   S_BID,
    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic                  S_BREADY,
    input  logic [ID_WIDTH-1:0]   S_ARID,
    input  logic [ADDR_WIDTH-1:0] S_ARADDR,
    input  logic [3:0]            S_ARLEN,
    input  logic [1:0]            S_ARBURST,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    output logic [ID_WIDTH-1:0]   S_RID,
    output logic [31:0]           S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RLAST,
    output logic                  S_RVALID,
    input  logic                  S_RREADY
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
`ifdef AXI_SLV_RANGE_CHECK_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return RANGE_CHK && (((a - BASE_ADDR) >> (IDX_W + 2)) != '0);
    endfunction

    function automatic logic burst_bad(input logic [3:0] len, input logic [1:0] burst);
        return (burst == 2'b11) ||
               ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    // WRAP keeps the bits above the (len+1)*4 window and wraps the bits inside it
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [3:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] mask;
        mask = ADDR_WIDTH'({len, 2'b11});
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && !burst_bad(len, burst))
            return (a & ~mask) | ((a + ADDR_WIDTH'(4)) & mask);
        return a + ADDR_WIDTH'(4);
    endfunction

    logic [31:0] mem_q [MEM_WORDS];

    wstate_e               wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [3:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  werr_q, werr_d;

    rstate_e               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_nxt;
    logic [3:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rerr_q, rerr_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, mem_we;
    logic [IDX_W-1:0] widx;

    assign S_AWREADY = (wstate_q == W_IDLE) && !ARESET;
    assign S_WREADY  = (wstate_q == W_DATA) && !ARESET;
    assign S_BVALID  = (wstate_q == W_RESP) && !ARESET;
    assign S_BID     = (wstate_q == W_RESP) ? wid_q : '0;
    assign S_BRESP   = ((wstate_q == W_RESP) && werr_q) ? 2'b10 : 2'b00;

    assign S_ARREADY = (rstate_q == R_IDLE) && !ARESET;
    assign S_RVALID  = (rstate_q == R_DATA) && !ARESET;
    assign S_RID     = (rstate_q == R_DATA) ? rid_q : '0;
    assign S_RDATA   = (rstate_q == R_DATA) ? rdata_q : '0;
    assign S_RRESP   = ((rstate_q == R_DATA) && rerr_q) ? 2'b10 : 2'b00;
    assign S_RLAST   = (rstate_q == R_DATA) && (rcnt_q == rlen_q);

    assign aw_hs  = S_AWVALID && S_AWREADY;
    assign w_hs   = S_WVALID && S_WREADY;
    assign b_hs   = S_BVALID && S_BREADY;
    assign ar_hs  = S_ARVALID && S_ARREADY;
    assign r_hs   = S_RVALID && S_RREADY;
    assign widx   = word_idx(waddr_q);
    assign mem_we = w_hs && !out_of_range(waddr_q);

    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wburst_d = wburst_q;
        wcnt_d   = wcnt_q;
        werr_d   = werr_q;
        case (wstate_q)
            W_IDLE: if (aw_hs) begin
                wstate_d = W_DATA;
                wid_d    = S_AWID;
                waddr_d  = S_AWADDR;
                wlen_d   = S_AWLEN;
                wburst_d = S_AWBURST;
                wcnt_d   = '0;
                werr_d   = burst_bad(S_AWLEN, S_AWBURST);
            end
            W_DATA: if (w_hs) begin
                wcnt_d  = wcnt_q + 4'd1;
                waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                if (((wcnt_q == wlen_q) != S_WLAST) || out_of_range(waddr_q)) werr_d = 1'b1;
                if (wcnt_q == wlen_q) wstate_d = W_RESP;
            end
            W_RESP: if (b_hs) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read data is registered at each beat so it stays stable under back-pressure
    always_comb begin
        rstate_d  = rstate_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        raddr_nxt = next_addr(raddr_q, rlen_q, rburst_q);
        case (rstate_q)
            R_IDLE: if (ar_hs) begin
                rstate_d = R_DATA;
                rid_d    = S_ARID;
                raddr_d  = S_ARADDR;
                rlen_d   = S_ARLEN;
                rburst_d = S_ARBURST;
                rcnt_d   = '0;
                rdata_d  = out_of_range(S_ARADDR) ? '0 : mem_q[word_idx(S_ARADDR)];
                rerr_d   = burst_bad(S_ARLEN, S_ARBURST) || out_of_range(S_ARADDR);
            end
            R_DATA: if (r_hs) begin
                if (rcnt_q == rlen_q) begin
                    rstate_d = R_IDLE;
                end else begin
                    rcnt_d  = rcnt_q + 4'd1;
                    raddr_d = raddr_nxt;
                    rdata_d = out_of_range(raddr_nxt) ? '0 : mem_q[word_idx(raddr_nxt)];
                    rerr_d  = burst_bad(rlen_q, rburst_q) || out_of_range(raddr_nxt);
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wburst_q <= '0;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rburst_q <= '0;
            rcnt_q   <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wburst_q <= wburst_d;
            wcnt_q   <= wcnt_d;
            werr_q   <= werr_d;
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rburst_q <= rburst_d;
            rcnt_q   <= rcnt_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge ACLK) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (mem_we && S_WSTRB[b]) mem_q[widx][8*b +: 8] <= S_WDATA[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_axi_slave_responder.sv
// Directed + randomized bench for axi_slave_responder against a word-array reference model.
module tb_axi_slave_responder;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  S_AWID = '0, S_ARID = '0, S_BID, S_RID;
    logic [31:0] S_AWADDR = '0, S_ARADDR = '0, S_WDATA = '0, S_RDATA;
    logic [3:0]  S_AWLEN = '0, S_ARLEN = '0, S_WSTRB = '0;
    logic [1:0]  S_AWBURST = '0, S_ARBURST = '0, S_BRESP, S_RRESP;
    logic        S_AWVALID = 1'b0, S_AWREADY, S_WLAST = 1'b0, S_WVALID = 1'b0, S_WREADY;
    logic        S_BVALID, S_BREADY = 1'b0, S_ARVALID = 1'b0, S_ARREADY;
    logic        S_RLAST, S_RVALID, S_RREADY = 1'b0;

    axi_slave_responder #(.ID_WIDTH(4), .ADDR_WIDTH(32), .MEM_WORDS(16), .BASE_ADDR(32'h0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWBURST(S_AWBURST),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARBURST(S_ARBURST),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    always #5 ACLK = ~ACLK;

`ifdef AXI_SLV_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif
    localparam int unsigned TMO = 64;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] model [16];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];

    function automatic logic wrap_ok(int unsigned len);
        return len == 1 || len == 3 || len == 7 || len == 15;
    endfunction

    function automatic logic bad(int unsigned len, int unsigned burst);
        return burst == 3 || (burst == 2 && !wrap_ok(len));
    endfunction

    // Byte address of beat i, straight from the burst-type definitions
    function automatic int unsigned baddr(int unsigned a, int unsigned len, int unsigned burst, int unsigned i);
        int unsigned win, lo;
        if (burst == 0) return a;
        if (burst == 2 && wrap_ok(len)) begin
            win = (len + 1) * 4;
            lo  = (a / win) * win;
            return lo + ((a - lo) + 4 * i) % win;
        end
        return a + 4 * i;
    endfunction

    function automatic logic oor(int unsigned a);
        return RC && (a >= 64);
    endfunction

    function automatic int unsigned widx(int unsigned a);
        return (a / 4) % 16;
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(string tag);
        errors++;
        $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, TMO, TMO);
    endtask

    task automatic do_aw(int unsigned id, int unsigned addr, int unsigned len, int unsigned burst);
        int unsigned n = 0;
        S_AWID = 4'(id); S_AWADDR = addr; S_AWLEN = 4'(len); S_AWBURST = 2'(burst); S_AWVALID = 1'b1;
        while (S_AWREADY !== 1'b1 && n < TMO) begin step(); n++; end
        if (n >= TMO) tmo("awready");
        step();
        S_AWVALID = 1'b0;
    endtask

    task automatic w_beat(logic [31:0] d, logic [3:0] s, logic last);
        int unsigned n = 0;
        S_WDATA = d; S_WSTRB = s; S_WLAST = last; S_WVALID = 1'b1;
        while (S_WREADY !== 1'b1 && n < TMO) begin step(); n++; end
        if (n >= TMO) tmo("wready");
        step();
        S_WVALID = 1'b0; S_WLAST = 1'b0;
    endtask

    task automatic model_beat(int unsigned a, logic [31:0] d, logic [3:0] s);
        if (!oor(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic wr_burst(int unsigned id, int unsigned addr, int unsigned len, int unsigned burst,
                            int unsigned wlast_at);
        int unsigned n = 0;
        logic eerr;
        eerr = bad(len, burst) || (wlast_at != len);
        do_aw(id, addr, len, burst);
        for (int unsigned i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 1)) step();
            w_beat(wdat[i], wstb[i], i == wlast_at);
            model_beat(baddr(addr, len, burst, i), wdat[i], wstb[i]);
            if (oor(baddr(addr, len, burst, i))) eerr = 1'b1;
        end
        repeat ($urandom_range(0, 2)) step();
        S_BREADY = 1'b1;
        while (S_BVALID !== 1'b1 && n < TMO) begin step(); n++; end
        if (n >= TMO) tmo("bvalid");
        chk("bid", 32'(S_BID), id);
        chk("bresp", 32'(S_BRESP), eerr ? 32'd2 : 32'd0);
        step();
        S_BREADY = 1'b0;
        chk("awready_after_b", 32'(S_AWREADY), 32'd1);
    endtask

    task automatic rd_burst(int unsigned id, int unsigned addr, int unsigned len, int unsigned burst,
                            int unsigned stall_at);
        int unsigned n, ea;
        logic [31:0] ed;
        logic [1:0]  er;
        n = 0;
        S_ARID = 4'(id); S_ARADDR = addr; S_ARLEN = 4'(len); S_ARBURST = 2'(burst); S_ARVALID = 1'b1;
        while (S_ARREADY !== 1'b1 && n < TMO) begin step(); n++; end
        if (n >= TMO) tmo("arready");
        step();
        S_ARVALID = 1'b0;
        chk("rvalid_after_ar", 32'(S_RVALID), 32'd1);
        for (int unsigned i = 0; i <= len; i++) begin
            ea = baddr(addr, len, burst, i);
            ed = oor(ea) ? 32'h0 : model[widx(ea)];
            er = (bad(len, burst) || oor(ea)) ? 2'd2 : 2'd0;
            if (i == stall_at) begin
                S_RREADY = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    chk($sformatf("stall_rdata[%0d]", i), S_RDATA, ed);
                    chk($sformatf("stall_rlast[%0d]", i), 32'(S_RLAST), 32'(i == len));
                    chk($sformatf("stall_rid[%0d]", i), 32'(S_RID), id);
                    step();
                end
            end
            S_RREADY = 1'b1;
            n = 0;
            while (S_RVALID !== 1'b1 && n < TMO) begin step(); n++; end
            if (n >= TMO) tmo("rvalid");
            chk($sformatf("rdata[%0d]", i), S_RDATA, ed);
            chk($sformatf("rresp[%0d]", i), 32'(S_RRESP), 32'(er));
            chk($sformatf("rlast[%0d]", i), 32'(S_RLAST), 32'(i == len));
            chk($sformatf("rid[%0d]", i), 32'(S_RID), id);
            step();
            if ($urandom_range(0, 3) == 0) begin S_RREADY = 1'b0; step(); end
        end
        S_RREADY = 1'b0;
    endtask

    initial begin
        int unsigned bst, ln, ad;
        repeat (3) step();
        chk("rst_awready", 32'(S_AWREADY), 0);
        chk("rst_arready", 32'(S_ARREADY), 0);
        chk("rst_wready", 32'(S_WREADY), 0);
        chk("rst_bvalid", 32'(S_BVALID), 0);
        chk("rst_rvalid", 32'(S_RVALID), 0);
        chk("rst_rdata", S_RDATA, 0);
        chk("rst_rlast", 32'(S_RLAST), 0);
        chk("rst_ids", 32'({S_BID, S_RID}), 0);
        chk("rst_resp", 32'({S_BRESP, S_RRESP}), 0);
        ARESET = 1'b0;
        #1;
        chk("post_rst_awready", 32'(S_AWREADY), 1);
        chk("post_rst_arready", 32'(S_ARREADY), 1);

        for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        wr_burst(0, 32'h0, 15, 1, 15);

        for (int i = 0; i < 4; i++) wdat[i] = 32'(8'h11 * (i + 1));
        wr_burst(5, 32'h0, 3, 1, 3);
        rd_burst(9, 32'h0, 3, 1, 99);

        wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
        wr_burst(2, 32'h8, 3, 2, 3);
        rd_burst(3, 32'h0, 3, 1, 99);

        wdat[0] = 32'h1111_1111; wstb[0] = 4'h1;
        wdat[1] = 32'h2222_2222; wstb[1] = 4'h2;
        wdat[2] = 32'h4444_4444; wstb[2] = 4'h4;
        wr_burst(7, 32'h4, 2, 0, 2);
        rd_burst(1, 32'h4, 0, 1, 99);

        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        wr_burst(4, 32'h20, 3, 1, 1);
        rd_burst(6, 32'h20, 3, 1, 1);

        for (int i = 0; i < 8; i++) wdat[i] = $urandom;
        do_aw(3, 32'h10, 7, 1);
        for (int unsigned i = 0; i < 2; i++) begin
            w_beat(wdat[i], 4'hF, 1'b0);
            model_beat(32'h10 + 4 * i, wdat[i], 4'hF);
        end
        S_WDATA = wdat[2]; S_WSTRB = 4'hF; S_WVALID = 1'b1; ARESET = 1'b1;
        step();
        chk("rst_mid_bvalid", 32'(S_BVALID), 0);
        chk("rst_mid_awready", 32'(S_AWREADY), 0);
        chk("rst_mid_wready", 32'(S_WREADY), 0);
        ARESET = 1'b0; S_WVALID = 1'b0;
        #1;
        chk("rst_rel_awready", 32'(S_AWREADY), 1);
        rd_burst(8, 32'h0, 7, 1, 99);

        rd_burst(2, 32'h40, 0, 1, 99);

        for (int it = 0; it < 24; it++) begin
            bst = $urandom_range(0, 3);
            ln  = $urandom_range(0, 15);
            ad  = $urandom_range(0, 63);
            for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
            wr_burst($urandom_range(0, 15), ad, ln, bst, ln);
            rd_burst($urandom_range(0, 15), ad, ln, bst, $urandom_range(0, ln + 4));
            rd_burst($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 15),
                     $urandom_range(0, 3), 99);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not complete");
    end

endmodule
